// File: rtl/uart_core.sv
// Full-duplex UART with configurable framing, 3-sample majority-voted RX and an RX FIFO
// that carries per-word parity/framing error flags alongside the data.
module uart_core #(
  parameter int unsigned CLK_FRQ   = 27000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned RX_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_out,
  input  logic                        rx_in,
  output logic [7:0]                  rx_data,
  output logic                        rx_perr,
  output logic                        rx_ferr,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        rx_overrun,
  input  logic                        rx_ovr_clear
);

  localparam int unsigned CYCLE = CLK_FRQ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(STOP_BITS * CYCLE + 1);
  localparam int unsigned PTR_W = $clog2(RX_DEPTH);
  localparam int unsigned MID   = CYCLE / 2;

  localparam logic [7:0]       DATA_MASK = 8'(8'hFF >> (8 - DATA_BITS));
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CYCLE - 1);
  localparam logic [CNT_W-1:0] STOP_END  = CNT_W'(STOP_BITS * CYCLE - 1);
  localparam logic [CNT_W-1:0] SMP_0     = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SMP_1     = CNT_W'(MID);
  localparam logic [CNT_W-1:0] SMP_2     = CNT_W'(MID + 1);
  localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(RX_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------- Transmitter ----------------
  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_par_q, tx_par_d;
  logic             tx_out_q, tx_out_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_out_d   = tx_out_q;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        tx_out_d = 1'b1;
        if (tx_valid) begin
          tx_state_d = StStart;
          tx_shift_d = tx_data & DATA_MASK;
          tx_par_d   = (^(tx_data & DATA_MASK)) ^ PAR_ODD;
          tx_out_d   = 1'b0;
        end
      end
      StStart: begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = StData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_out_d   = tx_shift_q[0];
        end
      end
      StData: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_BIT) begin
            if (PARITY != 0) begin
              tx_state_d = StParity;
              tx_out_d   = tx_par_q;
            end else begin
              tx_state_d = StStop;
              tx_out_d   = 1'b1;
            end
          end else begin
            tx_out_d = tx_shift_q[1];
          end
        end
      end
      StParity: begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = StStop;
          tx_cnt_d   = '0;
          tx_out_d   = 1'b1;
        end
      end
      StStop: begin
        if (tx_cnt_q == STOP_END) begin
          tx_state_d = StIdle;
          tx_cnt_d   = '0;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign tx_ready = (tx_state_q == StIdle);
  assign tx_out   = tx_out_q;

  // ---------------- Receiver ----------------
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [1:0]       rx_smp_q, rx_smp_d;
  logic             rx_perr_q, rx_perr_d;
  logic             rx_ferr_q, rx_ferr_d;
  logic             push_q, push_d;
  logic             vote;

  assign vote = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s2_q) | (rx_smp_q[1] & rx_s2_q);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_smp_d   = rx_smp_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    push_d     = 1'b0;
    if (rx_cnt_q == SMP_0) rx_smp_d[0] = rx_s2_q;
    if (rx_cnt_q == SMP_1) rx_smp_d[1] = rx_s2_q;
    unique case (rx_state_q)
      StIdle: begin
        // Count 1 on entry so that count 0 lines up with the first low synchronized sample.
        rx_cnt_d = CNT_W'(1);
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = StStart;
          rx_perr_d  = 1'b0;
        end
      end
      StStart: begin
        if (rx_cnt_q == SMP_2 && vote) begin
          rx_state_d = StIdle;
        end else if (rx_cnt_q == BIT_END) begin
          rx_state_d = StData;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      StData: begin
        if (rx_cnt_q == SMP_2) rx_shift_d[rx_bit_q] = vote;
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? StParity : StStop;
        end
      end
      StParity: begin
        if (rx_cnt_q == SMP_2) rx_perr_d = vote ^ (^rx_shift_q) ^ PAR_ODD;
        if (rx_cnt_q == BIT_END) begin
          rx_state_d = StStop;
          rx_cnt_d   = '0;
        end
      end
      StStop: begin
        if (rx_cnt_q == SMP_2) begin
          rx_ferr_d  = ~vote;
          push_d     = 1'b1;
          rx_state_d = StIdle;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_smp_q   <= '1;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      push_q     <= 1'b0;
    end else begin
      rx_s1_q    <= rx_in;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_smp_q   <= rx_smp_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      push_q     <= push_d;
    end
  end

  // ---------------- RX FIFO ----------------
  logic [9:0]       mem_q [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             valid_q, overrun_q;
  logic             pop, wr_en, drop;

  assign pop   = valid_q & rx_ready;
  assign wr_en = push_q & ((count_q != FULL) | pop);
  assign drop  = push_q & (count_q == FULL) & ~pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {rx_shift_q, rx_perr_q, rx_ferr_q};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      valid_q   <= (count_d != '0);
      overrun_q <= drop | (overrun_q & ~rx_ovr_clear);
    end
  end

  assign rx_data    = mem_q[rd_ptr_q][9:2];
  assign rx_perr    = mem_q[rd_ptr_q][1];
  assign rx_ferr    = mem_q[rd_ptr_q][0];
  assign rx_valid   = valid_q;
  assign rx_count   = count_q;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_core.sv
// Randomized bench for uart_core: an 8N1 instance in loopback and a 7E2 instance fed either by
// its own TX or by bit-banged frames, both checked against a frame-level reference model.
module tb_uart_core;

  localparam int CYC = 10;

  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  // 8N1 instance, permanently looped back
  logic [7:0] a_tx_data;
  logic       a_tx_valid, a_tx_ready, a_tx_out;
  logic [7:0] a_rx_data;
  logic       a_rx_perr, a_rx_ferr, a_rx_valid, a_rx_ready, a_rx_overrun, a_ovr_clear;
  logic [2:0] a_rx_count;

  // 7E2 instance
  logic [7:0] b_tx_data;
  logic       b_tx_valid, b_tx_ready, b_tx_out, b_rx_in;
  logic [7:0] b_rx_data;
  logic       b_rx_perr, b_rx_ferr, b_rx_valid, b_rx_ready, b_rx_overrun, b_ovr_clear;
  logic [2:0] b_rx_count;
  logic       b_loop, b_rx_drv;

  assign b_rx_in = b_loop ? b_tx_out : b_rx_drv;

  uart_core #(
    .CLK_FRQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .RX_DEPTH(4)
  ) u_a (
    .clk(clk), .reset(reset), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .tx_out(a_tx_out), .rx_in(a_tx_out), .rx_data(a_rx_data),
    .rx_perr(a_rx_perr), .rx_ferr(a_rx_ferr), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_count(a_rx_count), .rx_overrun(a_rx_overrun), .rx_ovr_clear(a_ovr_clear)
  );

  uart_core #(
    .CLK_FRQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
    .RX_DEPTH(4)
  ) u_b (
    .clk(clk), .reset(reset), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .tx_out(b_tx_out), .rx_in(b_rx_in), .rx_data(b_rx_data),
    .rx_perr(b_rx_perr), .rx_ferr(b_rx_ferr), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_count(b_rx_count), .rx_overrun(b_rx_overrun), .rx_ovr_clear(b_ovr_clear)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_a [$];
  logic [9:0] exp_b [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits (all remaining bits 1).
  function automatic void make_frame(input int dbits, input int par, input int stops,
                                     input logic [7:0] d, output logic [15:0] f, output int n);
    logic [7:0] dm;
    dm = d & 8'(8'hFF >> (8 - dbits));
    f = '1;
    n = 0;
    f[n] = 1'b0;
    n++;
    for (int i = 0; i < dbits; i++) begin
      f[n] = dm[i];
      n++;
    end
    if (par != 0) begin
      f[n] = (^dm) ^ (par == 1);
      n++;
    end
    n += stops;
  endfunction

  // What a receiver should report for a given line frame: {data, perr, ferr}.
  function automatic logic [9:0] decode_frame(input int dbits, input int par, input logic [15:0] f);
    logic [7:0] d;
    logic       perr, ferr;
    int         sp;
    d = '0;
    for (int i = 0; i < dbits; i++) d[i] = f[i+1];
    perr = (par != 0) && (f[dbits+1] != ((^d) ^ (par == 1)));
    sp   = dbits + 1 + ((par != 0) ? 1 : 0);
    ferr = !f[sp];
    return {d, perr, ferr};
  endfunction

  function automatic logic tx_ready_of(input int which);
    return (which != 0) ? b_tx_ready : a_tx_ready;
  endfunction

  function automatic logic tx_out_of(input int which);
    return (which != 0) ? b_tx_out : a_tx_out;
  endfunction

  // Called at a negedge; returns at the negedge where tx_ready is back, so calls chain gap-free.
  task automatic tx_send(input int which, input logic [7:0] d);
    logic [15:0] f;
    int          n, bad, low, w;
    string       p;
    p = (which != 0) ? "b" : "a";
    if (which != 0) make_frame(7, 2, 2, d, f, n);
    else            make_frame(8, 0, 1, d, f, n);
    w = 0;
    while (!tx_ready_of(which) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check({p, "_tx_ready_wait"}, 32'(tx_ready_of(which)), 32'd1);
    if (which != 0) begin
      b_tx_valid = 1'b1;
      b_tx_data  = d;
      if (b_loop) exp_b.push_back(decode_frame(7, 2, f));
    end else begin
      a_tx_valid = 1'b1;
      a_tx_data  = d;
      exp_a.push_back(decode_frame(8, 0, f));
    end
    @(posedge clk);
    #1;
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
    a_tx_data  = 8'($urandom);
    b_tx_data  = 8'($urandom);
    bad = 0;
    low = 0;
    for (int i = 0; i < n * CYC; i++) begin
      @(negedge clk);
      if (tx_out_of(which) !== f[i/CYC]) bad++;
      if (!tx_ready_of(which)) low++;
    end
    check($sformatf("%s_tx_wave_%02h", p, d), 32'(bad), 32'd0);
    check({p, "_tx_busy_len"}, 32'(low), 32'(n * CYC));
    @(negedge clk);
    check({p, "_tx_ready_after"}, 32'(tx_ready_of(which)), 32'd1);
    check({p, "_tx_idle_high"}, 32'(tx_out_of(which)), 32'd1);
  endtask

  // Called at a negedge; spike >= 0 inverts the line for that one clock of the frame.
  task automatic rx_send(input logic [15:0] f, input int n, input int spike);
    for (int i = 0; i < n * CYC; i++) begin
      b_rx_drv = f[i/CYC] ^ (i == spike);
      @(negedge clk);
    end
    b_rx_drv = 1'b1;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("a_rx_drained", 32'(exp_a.size()), 32'd0);
    check("b_rx_drained", 32'(exp_b.size()), 32'd0);
  endtask

  task automatic set_b_ready(input logic v);
    @(posedge clk);
    #1;
    b_rx_ready = v;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && a_rx_valid && a_rx_ready) begin
      if (exp_a.size() == 0) check("a_rx_unexpected", 32'(exp_a.size()), 32'd1);
      else check("a_rx_word", 32'({a_rx_data, a_rx_perr, a_rx_ferr}), 32'(exp_a.pop_front()));
    end
    if (!reset && b_rx_valid && b_rx_ready) begin
      if (exp_b.size() == 0) check("b_rx_unexpected", 32'(exp_b.size()), 32'd1);
      else check("b_rx_word", 32'({b_rx_data, b_rx_perr, b_rx_ferr}), 32'(exp_b.pop_front()));
    end
  end

  initial begin
    logic [15:0] f;
    int          n, kind, spike;
    logic [7:0]  d;
    reset = 1'b1;
    a_tx_data = '0; a_tx_valid = 1'b0; a_rx_ready = 1'b1; a_ovr_clear = 1'b0;
    b_tx_data = '0; b_tx_valid = 1'b0; b_rx_ready = 1'b1; b_ovr_clear = 1'b0;
    b_loop = 1'b0; b_rx_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    check("rst_a_tx_out", 32'(a_tx_out), 32'd1);
    check("rst_a_tx_ready", 32'(a_tx_ready), 32'd1);
    check("rst_a_rx_count", 32'(a_rx_count), 32'd0);
    check("rst_b_tx_out", 32'(b_tx_out), 32'd1);
    check("rst_b_tx_ready", 32'(b_tx_ready), 32'd1);
    check("rst_b_rx_valid", 32'(b_rx_valid), 32'd0);
    check("rst_b_rx_count", 32'(b_rx_count), 32'd0);
    check("rst_b_rx_overrun", 32'(b_rx_overrun), 32'd0);
    check("rst_b_rx_perr", 32'(b_rx_perr), 32'd0);
    check("rst_b_rx_ferr", 32'(b_rx_ferr), 32'd0);

    // 8N1 waveform of 0xA5, then random back-to-back words through the loopback
    tx_send(0, 8'hA5);
    repeat (4) tx_send(0, 8'($urandom));

    // 7E2 loopback, back-to-back
    b_loop = 1'b1;
    tx_send(1, 8'h55);
    tx_send(1, 8'h7F);
    tx_send(1, 8'h00);
    repeat (4) tx_send(1, 8'($urandom));
    wait_drain();
    b_loop = 1'b0;

    // Corrupted parity, then corrupted stop bit
    make_frame(7, 2, 2, 8'h41, f, n);
    f[8] = ~f[8];
    exp_b.push_back(decode_frame(7, 2, f));
    rx_send(f, n, -1);
    make_frame(7, 2, 2, 8'h42, f, n);
    f[9] = 1'b0;
    exp_b.push_back(decode_frame(7, 2, f));
    rx_send(f, n, -1);
    wait_drain();

    // Random frames with random faults and mid-bit spikes
    repeat (8) begin
      d = 8'($urandom);
      make_frame(7, 2, 2, d, f, n);
      kind = int'($urandom_range(0, 2));
      if (kind == 1) f[8] = ~f[8];
      if (kind == 2) f[9] = 1'b0;
      spike = ($urandom_range(0, 1) != 0) ? (1 + int'($urandom_range(0, 6))) * CYC + CYC / 2 : -1;
      exp_b.push_back(decode_frame(7, 2, f));
      rx_send(f, n, spike);
    end
    wait_drain();

    // Short low glitch must not produce a word; a spiked frame still decodes
    b_rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    b_rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_word", 32'(b_rx_count), 32'd0);
    make_frame(7, 2, 2, 8'h2B, f, n);
    exp_b.push_back(decode_frame(7, 2, f));
    rx_send(f, n, 4 * CYC + CYC / 2);
    wait_drain();

    // Overrun: five words into a four-deep FIFO with no reader
    set_b_ready(1'b0);
    for (int i = 0; i < 5; i++) begin
      make_frame(7, 2, 2, 8'($urandom), f, n);
      if (i < 4) exp_b.push_back(decode_frame(7, 2, f));
      rx_send(f, n, -1);
    end
    repeat (20) @(negedge clk);
    check("ovr_count_full", 32'(b_rx_count), 32'd4);
    check("ovr_flag_set", 32'(b_rx_overrun), 32'd1);
    check("ovr_valid", 32'(b_rx_valid), 32'd1);
    set_b_ready(1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    check("ovr_count_empty", 32'(b_rx_count), 32'd0);
    check("ovr_flag_sticky", 32'(b_rx_overrun), 32'd1);
    @(posedge clk);
    #1 b_ovr_clear = 1'b1;
    @(posedge clk);
    #1 b_ovr_clear = 1'b0;
    @(negedge clk);
    check("ovr_flag_cleared", 32'(b_rx_overrun), 32'd0);

    // Reset mid-frame on both directions, with a word already buffered
    set_b_ready(1'b0);
    make_frame(7, 2, 2, 8'($urandom), f, n);
    rx_send(f, n, -1);
    repeat (20) @(negedge clk);
    check("pre_rst_count", 32'(b_rx_count), 32'd1);
    b_tx_valid = 1'b1;
    b_tx_data  = 8'($urandom);
    @(posedge clk);
    #1 b_tx_valid = 1'b0;
    @(negedge clk);
    make_frame(7, 2, 2, 8'h00, f, n);
    for (int i = 0; i < 45; i++) begin
      b_rx_drv = f[i/CYC];
      @(negedge clk);
    end
    reset    = 1'b1;
    b_rx_drv = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_out", 32'(b_tx_out), 32'd1);
    check("mid_rst_tx_ready", 32'(b_tx_ready), 32'd1);
    check("mid_rst_rx_count", 32'(b_rx_count), 32'd0);
    check("mid_rst_rx_valid", 32'(b_rx_valid), 32'd0);
    repeat (30 * CYC) @(negedge clk);
    check("mid_rst_partial_dropped", 32'(b_rx_count), 32'd0);
    set_b_ready(1'b1);
    b_loop = 1'b1;
    tx_send(1, 8'h3C);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART, the successor to the fixed 8N1 uart_tx/uart_rx pair. It has configurable data width, parity and stop bits, and 3-sample majority voting on RX. Received words, with per-word error flags, go into a first-word-fall-through FIFO. It sits between the CPU bus glue and the board serial pins; both sides use valid/ready handshakes.

## Interface
- CLK_FRQ, 27000000: clock frequency in Hz
- BAUD_RATE, 115200: serial baud rate; CYCLE = CLK_FRQ / BAUD_RATE (integer division), must be >= 8
- DATA_BITS, 8: data bits per frame, 5..8
- PARITY, 0: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1: 1 or 2 (TX); RX always checks only the first stop bit
- RX_DEPTH, 4: RX FIFO entries, power of two, >= 2

Ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  word to send; bits above DATA_BITS-1 ignored
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter idle; accept on tx_valid & tx_ready
- tx_out  out  1  serial output, idle high
- rx_in  in  1  serial input, asynchronous
- rx_data  out  8  FIFO head data, zero-extended above DATA_BITS
- rx_perr  out  1  FIFO head parity error (always 0 when PARITY = 0)
- rx_ferr  out  1  FIFO head framing error (first stop bit sampled low)
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop head on rx_valid & rx_ready
- rx_count  out  $clog2(RX_DEPTH)+1  FIFO occupancy
- rx_overrun  out  1  sticky: a received word was dropped on a full FIFO
- rx_ovr_clear  in  1  clears rx_overrun

## Operation
- Reset values: tx_out = 1, tx_ready = 1, rx_valid = 0, rx_count = 0, rx_overrun = 0, rx_perr = 0, rx_ferr = 0. Both FSMs go to IDLE, the FIFO is flushed, and the synchronizer flops are set to 1.
- Reset mid-frame aborts the frame. tx_out is 1 at the first edge after reset; a partially received word is discarded.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY = 0) -> STOP -> IDLE. Each bit lasts exactly CYCLE clocks.
  - Bits are sent LSB first.
  - Even parity bit = XOR of the data bits; odd parity bit = its inverse.
  - STOP holds 1 for STOP_BITS * CYCLE clocks.
- tx_ready is 1 only in IDLE. tx_data is latched at acceptance, so changing tx_data afterwards has no effect on the frame in flight.
- RX front end: 2-flop synchronizer. A falling edge of the synchronized signal in IDLE enters START.
- RX bit timing: a bit counter runs 0..CYCLE-1. The bit value is the majority of the samples at counts CYCLE/2-1, CYCLE/2 and CYCLE/2+1, and is resolved at CYCLE/2+1.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - START: a voted value of 1 is a false start. Return to IDLE and push nothing.
  - STOP: resolved at mid-bit, then return to IDLE immediately so the next start edge is caught.
- Push {data, perr, ferr} into the FIFO in the cycle after the STOP vote resolves.
  - If the FIFO is full and no pop happens that cycle, drop the word and set rx_overrun.
  - A push and a pop in the same cycle on a full FIFO both take effect: count is unchanged, no overrun.
  - A push and a pop in the same cycle on an empty FIFO: the push lands and rx_valid rises next cycle.
- rx_overrun is set by a drop and cleared by rx_ovr_clear. If both happen in the same cycle, set wins.
- FIFO read/write pointers wrap modulo RX_DEPTH. rx_count ranges 0..RX_DEPTH.

## Timing
- TX: accept at edge k. tx_out = 0 for clocks k+1 .. k+CYCLE. Frame length N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits. tx_ready = 1 at k+1+N*CYCLE.
- TX back-to-back: if tx_valid is held, the next acceptance happens on the first tx_ready cycle, giving zero idle gap.
- RX latency: rx_valid rises 2 clocks after the STOP vote edge (1 push + 1 registered flag). A pop updates rx_data/rx_valid on the next edge.
- Start-edge detect adds 2 synchronizer clocks plus 1 edge-register clock. RX therefore tolerates roughly ±4% baud mismatch at CYCLE >= 16.
- All outputs are registered.

## Test plan
- CLK_FRQ=1000000, BAUD_RATE=100000 (CYCLE=10), 8N1: send 0xA5 -> tx_out shows 0,1,0,1,0,0,1,0,1,1 for 10 clocks each; tx_ready low for exactly 100 clocks.
- Loopback (tx_out->rx_in), 7 data bits, even parity, 2 stop: send 0x55, 0x7F, 0x00 back-to-back -> rx_data = 0x55, 0x7F, 0x00; rx_perr = 0, rx_ferr = 0; TX frame length 110 clocks.
- Inject 0x41 on RX with an inverted parity bit, then 0x42 with stop bit = 0 -> first entry has perr = 1; second has ferr = 1, data 0x42.
- RX_DEPTH=4, rx_ready = 0, receive 5 words -> rx_count = 4, fifth word dropped, rx_overrun = 1. Pop all four -> the first four words come out in order. Pulse rx_ovr_clear -> rx_overrun = 0.
- 3-clock low glitch on rx_in, then a 1-clock spike inside a valid bit -> no word for the glitch; the spiked frame decodes correctly via the majority vote.
- Assert reset for 1 clock midway through a TX frame and an RX frame -> next edge: tx_out = 1, tx_ready = 1, rx_count = 0; a new 0x3C frame then sends and receives correctly.
